// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and
// the layout of a FIFO entry (flags sit directly above the data field).
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Flag offsets are relative to the top of the data field
  localparam int ENTRY_FERR_OFS = 0;
  localparam int ENTRY_PERR_OFS = 1;
  localparam int ENTRY_FLAG_W   = 2;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic single-clock show-ahead FIFO: head is presented combinationally,
// data output forced to 0 while empty. DEPTH must be a power of 2.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic                     o_Valid,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Full,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             rd_en;
  logic             wr_en;

  // A push into a full FIFO is still accepted when the head leaves this cycle
  assign rd_en   = i_Pop && (count != '0);
  assign wr_en   = i_Push && (!o_Full || rd_en);
  assign o_Full  = (count == FULL_CNT);
  assign o_Valid = (count != '0);
  assign o_Data  = o_Valid ? mem[rd_ptr] : '0;
  assign o_Count = count;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr] <= i_Data;
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver (5..9 data bits, 1/2 stop bits) feeding a show-ahead RX FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Rx_Serial,
  output logic                          o_Rx_Valid,
  input  logic                          i_Rx_Ready,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Frame_Err,
  output logic                          o_Parity_Err,
  output logic                          o_Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + ENTRY_FLAG_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST_IDX = 1'(STOP_BITS - 1);

  logic                 rx_sync_p0;
  logic                 rx_sync_p1;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 frame_err;
  logic                 par_err;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample;
  logic                 ferr_now;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;

  // Stage p0/p1: two-flop synchroniser, idle-high
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_Rx_Serial;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign sample   = (cnt == CNT_LAST);
  assign ferr_now = frame_err | ~rx_sync_p1;
  assign push     = (state == ST_STOP) && sample && (stop_idx == STOP_LAST_IDX);
  assign pop      = o_Rx_Valid && i_Rx_Ready;
  assign o_Busy   = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
  localparam logic       PAR_INIT      = (PARITY_ODD != 0);
  logic par_acc;

  // par_acc ends the data phase holding the parity bit the sender must emit
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      par_acc <= PAR_INIT;
      par_err <= 1'b0;
    end else if (sample && state == ST_DATA) begin
      par_acc <= par_acc ^ rx_sync_p1;
    end else if (sample && state == ST_PARITY) begin
      par_err <= par_acc ^ rx_sync_p1;
    end
  end
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign par_err = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      frame_err <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      o_Overrun <= push && fifo_full && !pop;
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          frame_err <= 1'b0;
          if (!rx_sync_p1) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= rx_sync_p1 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (sample) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state <= ST_AFTER_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (sample) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (sample) begin
            cnt       <= '0;
            frame_err <= ferr_now;
            stop_idx  <= stop_idx + 1'b1;
            // A bad stop bit may be a break; wait for the line to recover
            if (push) state <= ferr_now ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_sync_p1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (state == ST_DATA && sample) shreg <= {rx_sync_p1, shreg[DATA_BITS-1:1]};
  end

  always_comb begin
    entry = '0;
    entry[DATA_BITS-1:0]               = shreg;
    entry[DATA_BITS + ENTRY_FERR_OFS]  = ferr_now;
    entry[DATA_BITS + ENTRY_PERR_OFS]  = par_err;
  end

  uart_rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Push  (push),
    .i_Data  (entry),
    .i_Pop   (pop),
    .o_Valid (o_Rx_Valid),
    .o_Data  (head),
    .o_Full  (fifo_full),
    .o_Count (o_Fifo_Count)
  );

  assign o_Rx_Data    = head[DATA_BITS-1:0];
  assign o_Frame_Err  = head[DATA_BITS + ENTRY_FERR_OFS];
  assign o_Parity_Err = head[DATA_BITS + ENTRY_PERR_OFS];

endmodule
